// File: rtl/rand_range_gen.sv
// Galois-free Fibonacci LFSR with rejection-sampled draws in [0, N).
// States: IDLE accepts a request | DRAW samples masked candidates | HOLD presents the result.
module rand_range_gen #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  TAPS      = 32'h80200003,
    parameter logic [WIDTH-1:0]  SEED      = 32'hFFFFFFF1,
    parameter int unsigned       OUT_W     = 6,
    parameter int unsigned       MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_range,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic [WIDTH-1:0] raw,
    output logic             seed_zero,
    output logic             lockup_err
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_raw;
    logic               r_seed_zero;
    logic               r_lockup;
    logic [OUT_W-1:0]   r_range;
    logic [OUT_W-1:0]   w_range_nxt;
    logic [OUT_W-1:0]   r_mask;
    logic [OUT_W-1:0]   w_mask_nxt;
    logic [TRY_W-1:0]   r_tries;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   w_data_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               w_fb;
    logic [OUT_W-1:0]   w_cand;
    logic               w_hit;

    // Smears the top set bit downward: smallest all-ones value >= x.
    function automatic logic [OUT_W-1:0] fill_mask(input logic [OUT_W-1:0] x);
        logic [OUT_W-1:0] m;
        m = x;
        for (int i = 1; i < int'(OUT_W); i++) begin
            m = m | (x >> i);
        end
        return m;
    endfunction

    assign w_fb = ^(r_raw & TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_raw       <= SEED;
            r_seed_zero <= 1'b0;
            r_lockup    <= 1'b0;
        end else if (seed_load) begin
            r_raw       <= (seed_in == '0) ? SEED : seed_in;
            r_seed_zero <= (seed_in == '0);
            r_lockup    <= 1'b0;
        end else if (r_raw == '0) begin
            r_raw       <= SEED;
            r_seed_zero <= 1'b0;
            r_lockup    <= 1'b1;
        end else begin
            r_raw       <= {r_raw[WIDTH-2:0], w_fb};
            r_seed_zero <= 1'b0;
            r_lockup    <= 1'b0;
        end
    end

    // A zero range means the full 2^OUT_W span, so every candidate fits.
    assign w_cand = r_raw[OUT_W-1:0] & r_mask;
    assign w_hit  = (r_range == '0) || (w_cand < r_range);

    always_comb begin
        w_state_nxt   = r_state;
        w_range_nxt   = r_range;
        w_mask_nxt    = r_mask;
        w_tries_nxt   = r_tries;
        w_data_nxt    = r_data;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_DRAW;
                    w_range_nxt = req_range;
                    w_mask_nxt  = fill_mask(req_range - OUT_W'(1));
                    w_tries_nxt = '0;
                end
            end
            ST_DRAW: begin
                if (w_hit) begin
                    w_data_nxt    = w_cand;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_HOLD;
                end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
                    w_data_nxt    = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end else begin
                    w_tries_nxt = r_tries + TRY_W'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_range   <= '0;
            r_mask    <= '0;
            r_tries   <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_range   <= w_range_nxt;
            r_mask    <= w_mask_nxt;
            r_tries   <= w_tries_nxt;
            r_data    <= w_data_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_HOLD);
    assign rsp_data    = r_data;
    assign rsp_timeout = r_timeout;
    assign raw         = r_raw;
    assign seed_zero   = r_seed_zero;
    assign lockup_err  = r_lockup;

endmodule

// File: tb/tb_rand_range_gen.sv
// Bench for rand_range_gen: directed steps plus 1000 random-handshake draws against a
// parity-based LFSR model and a power-of-two mask rejection model.
module tb_rand_range_gen;

    localparam int          MAX_TRIES = 16;
    localparam logic [31:0] TAPS      = 32'h80200003;
    localparam logic [31:0] SEED      = 32'hFFFFFFF1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, seed_load, req_valid, req_ready, rsp_valid, rsp_ready;
    logic        rsp_timeout, seed_zero, lockup_err;
    logic [31:0] seed_in, raw;
    logic [5:0]  req_range, rsp_data;

    logic        b_rst_n, b_seed_load, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic        b_rsp_timeout, b_seed_zero, b_lockup_err;
    logic [31:0] b_seed_in, b_raw;
    logic [5:0]  b_req_range, b_rsp_data;

    rand_range_gen dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_range(req_range),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .raw(raw), .seed_zero(seed_zero), .lockup_err(lockup_err)
    );

    rand_range_gen #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .rst_n(b_rst_n), .seed_load(b_seed_load), .seed_in(b_seed_in),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_range(b_req_range),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_timeout(b_rsp_timeout), .raw(b_raw), .seed_zero(b_seed_zero),
        .lockup_err(b_lockup_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_raw;
    logic        m_sz, m_lk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'($countones(s & TAPS) % 2)};
    endfunction

    // One clock edge; the model of dut's LFSR advances from the inputs seen at that edge.
    task automatic tick();
        logic [31:0] prev;
        @(posedge clk);
        prev = m_raw;
        m_sz = 1'b0;
        m_lk = 1'b0;
        if (!rst_n) begin
            m_raw = SEED;
        end else if (seed_load) begin
            if (seed_in == 32'h0) begin
                m_raw = SEED;
                m_sz  = 1'b1;
            end else begin
                m_raw = seed_in;
            end
        end else if (prev == 32'h0) begin
            m_raw = SEED;
            m_lk  = 1'b1;
        end else begin
            m_raw = lfsr_next(prev);
        end
        #1;
        check("raw", raw, m_raw);
        check("seed_zero", 32'(seed_zero), 32'(m_sz));
        check("lockup_err", 32'(lockup_err), 32'(m_lk));
    endtask

    task automatic do_draw(input logic [5:0] n);
        int          ne, k, edges, hold_cyc;
        logic [5:0]  mask, exp_data;
        logic        exp_to;
        logic [31:0] v;
        ne = (n == 6'd0) ? 64 : int'(n);
        k = 0;
        while ((1 << k) < ne) k++;
        mask = 6'((1 << k) - 1);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_range = n;
        tick();

        // Candidates are the raw values the DUT sees at each following edge.
        v        = m_raw;
        exp_to   = 1'b1;
        exp_data = 6'd0;
        edges    = MAX_TRIES;
        for (int t = 0; t < MAX_TRIES; t++) begin
            if (int'(v[5:0] & mask) < ne) begin
                exp_data = v[5:0] & mask;
                exp_to   = 1'b0;
                edges    = t + 1;
                break;
            end
            v = lfsr_next(v);
        end

        req_valid = 1'($urandom_range(0, 1));
        req_range = 6'($urandom);
        check("draw_req_ready", 32'(req_ready), 32'd0);
        check("draw_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int e = 1; e < edges; e++) begin
            tick();
            check("draw_req_ready", 32'(req_ready), 32'd0);
            check("draw_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        check("hold_req_ready", 32'(req_ready), 32'd0);
        check("rsp_in_range", 32'(int'(rsp_data) < ne), 32'd1);

        hold_cyc = 0;
        do begin
            rsp_ready = (hold_cyc >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            req_valid = rsp_ready ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            hold_cyc++;
            if (rsp_ready) begin
                check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
                check("post_hs_req_ready", 32'(req_ready), 32'd1);
            end else begin
                check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                check("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
                check("hold_rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
                check("hold_req_ready", 32'(req_ready), 32'd0);
            end
        end while (!rsp_ready);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed_in = 32'h0;
        req_valid = 1'b0; req_range = 6'd0; rsp_ready = 1'b0;
        b_rst_n = 1'b0; b_seed_load = 1'b0; b_seed_in = 32'h0;
        b_req_valid = 1'b0; b_req_range = 6'd0; b_rsp_ready = 1'b0;
        m_raw = SEED;

        tick();
        check("rst_raw", raw, 32'hFFFFFFF1);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();
        check("seq1", raw, 32'hFFFFFFE3);
        tick();
        check("seq2", raw, 32'hFFFFFFC6);

        seed_load = 1'b1;
        seed_in   = 32'h0;
        tick();
        check("zero_seed_raw", raw, 32'hFFFFFFF1);
        check("zero_seed_pulse", 32'(seed_zero), 32'd1);
        seed_load = 1'b0;
        tick();
        check("zero_seed_clear", 32'(seed_zero), 32'd0);
        seed_load = 1'b1;
        seed_in   = 32'h12345678;
        tick();
        check("seed_load_raw", raw, 32'h12345678);
        seed_load = 1'b0;
        seed_in   = 32'h0;
        tick();

        dut.r_raw = 32'h0;
        m_raw     = 32'h0;
        tick();
        check("lockup_raw", raw, 32'hFFFFFFF1);
        check("lockup_pulse", 32'(lockup_err), 32'd1);
        tick();
        check("lockup_clear", 32'(lockup_err), 32'd0);

        do_draw(6'd1);
        do_draw(6'd0);
        do_draw(6'd2);
        do_draw(6'd63);
        do_draw(6'd33);
        for (int i = 0; i < 1000; i++) begin
            do_draw(6'd52);
        end

        req_valid = 1'b1;
        req_range = 6'd52;
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        tick();

        b_seed_load = 1'b1;
        b_seed_in   = 32'h0000003F;
        b_req_valid = 1'b1;
        b_req_range = 6'd33;
        tick();
        b_seed_load = 1'b0;
        b_req_valid = 1'b0;
        check("b_seed_raw", b_raw, 32'h0000003F);
        check("b_draw_req_ready", 32'(b_req_ready), 32'd0);
        tick();
        check("b_raw_step", b_raw, lfsr_next(32'h0000003F));
        check("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
        check("b_rsp_data", 32'(b_rsp_data), 32'd0);
        check("b_rsp_timeout", 32'(b_rsp_timeout), 32'd1);
        tick();
        check("b_hold_rsp_valid", 32'(b_rsp_valid), 32'd1);
        check("b_hold_rsp_timeout", 32'(b_rsp_timeout), 32'd1);
        b_rst_n = 1'b0;
        tick();
        check("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("b_rst_req_ready", 32'(b_req_ready), 32'd1);
        check("b_rst_rsp_timeout", 32'(b_rsp_timeout), 32'd0);
        check("b_rst_raw", b_raw, 32'hFFFFFFF1);
        b_rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
